// File: rtl/regwrite_arbiter_pkg.sv
// Shared types and default sizing for the register-file writeback path.
// The register file and the pipeline reuse these definitions.
package regwrite_arbiter_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_DEPTH    = 5;
    localparam int DEF_MAX_WAIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } arb_state_e;

endpackage

// File: rtl/regwrite_arbiter_starve_counter.sv
// Saturating wait counter that tracks how long the multi-cycle requester has been denied.
module starve_counter
    import regwrite_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic sat
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // Clear has priority so a grant in the same cycle always restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == LIMIT);

endmodule

// File: rtl/regwrite_arbiter.sv
// Two-requester writeback arbiter for the register file: the pipeline (A) normally wins,
// the mul/div unit (B) is forced through after MAX_WAIT consecutive denied cycles.
module regwrite_arbiter
    import regwrite_arbiter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [DEPTH-1:0] a_wr,
    input  logic [WIDTH-1:0] a_wd,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [DEPTH-1:0] b_wr,
    input  logic [WIDTH-1:0] b_wd,
    output logic             b_ready,
    output logic             RegWrite,
    output logic [DEPTH-1:0] WR,
    output logic [WIDTH-1:0] WD,
    output logic             b_starved
);

    arb_state_e       state_d, state_q;
    logic [DEPTH-1:0] wr_d, wr_q;
    logic [WIDTH-1:0] wd_d, wd_q;
    logic             cnt_clr;
    logic             cnt_inc;

    // Readys are gated by reset so nothing is accepted while the block is held.
    assign a_ready = rst & a_valid & ~b_starved;
    assign b_ready = rst & b_valid & (~a_valid | b_starved);

    assign cnt_clr = ~b_valid | b_ready;
    assign cnt_inc = b_valid & ~b_ready;

    starve_counter #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve (
        .clk(clk),
        .rst(rst),
        .clr(cnt_clr),
        .inc(cnt_inc),
        .sat(b_starved)
    );

    always_comb begin
        state_d = ST_IDLE;
        wr_d    = wr_q;
        wd_d    = wd_q;
        if (a_ready) begin
            state_d = ST_GNT_A;
            wr_d    = a_wr;
            wd_d    = a_wd;
        end else if (b_ready) begin
            state_d = ST_GNT_B;
            wr_d    = b_wr;
            wd_d    = b_wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wr_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            wd_q    <= wd_d;
        end
    end

    // Register 0 is hardwired, so an accepted write to it never raises the enable.
    assign RegWrite = (state_q != ST_IDLE) && (wr_q != '0);
    assign WR       = wr_q;
    assign WD       = wd_q;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Self-checking bench for regwrite_arbiter: directed scenarios plus a randomized run
// compared against a cycle-level reference model of the arbitration rules.
module tb_regwrite_arbiter;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 5;
    localparam int MAX_WAIT = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             a_valid = 1'b0;
    logic [DEPTH-1:0] a_wr = '0;
    logic [WIDTH-1:0] a_wd = '0;
    logic             a_ready;
    logic             b_valid = 1'b0;
    logic [DEPTH-1:0] b_wr = '0;
    logic [WIDTH-1:0] b_wd = '0;
    logic             b_ready;
    logic             RegWrite;
    logic [DEPTH-1:0] WR;
    logic [WIDTH-1:0] WD;
    logic             b_starved;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int               m_wait = 0;
    bit               m_rw   = 1'b0;
    logic [DEPTH-1:0] m_wr   = '0;
    logic [WIDTH-1:0] m_wd   = '0;

    regwrite_arbiter #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .a_valid(a_valid),
        .a_wr(a_wr),
        .a_wd(a_wd),
        .a_ready(a_ready),
        .b_valid(b_valid),
        .b_wr(b_wr),
        .b_wd(b_wd),
        .b_ready(b_ready),
        .RegWrite(RegWrite),
        .WR(WR),
        .WD(WD),
        .b_starved(b_starved)
    );

    always #5 clk = ~clk;

    function automatic bit exp_a_ready();
        return rst && a_valid && (m_wait != MAX_WAIT);
    endfunction

    function automatic bit exp_b_ready();
        return rst && b_valid && (!a_valid || (m_wait == MAX_WAIT));
    endfunction

    task automatic model_reset();
        m_wait = 0;
        m_rw   = 1'b0;
        m_wr   = '0;
        m_wd   = '0;
    endtask

    // Advance one clock; the model applies the grant decided from pre-edge inputs.
    task automatic tick();
        bit ga, gb;
        ga = exp_a_ready();
        gb = exp_b_ready();
        @(posedge clk);
        if (rst) begin
            if (ga) begin
                m_rw = (a_wr != 0);
                m_wr = a_wr;
                m_wd = a_wd;
            end else if (gb) begin
                m_rw = (b_wr != 0);
                m_wr = b_wr;
                m_wd = b_wd;
            end else begin
                m_rw = 1'b0;
            end
            if (gb || !b_valid) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_valid = 1'b1; a_wr = 5'd4; a_wd = $urandom();
        b_valid = 1'b1; b_wr = 5'd6; b_wd = $urandom();
        model_reset();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (RegWrite !== 1'b0 || WR !== '0 || WD !== '0) begin
                failures++;
                $display("FAIL reset_outputs: got RegWrite=%b WR=%0d WD=%h expected 0/0/0", RegWrite, WR, WD);
            end
            checks++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0 || b_starved !== 1'b0) begin
                failures++;
                $display("FAIL reset_readys: got a_ready=%b b_ready=%b b_starved=%b expected 0/0/0", a_ready, b_ready, b_starved);
            end
            tick();
        end
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_a_only();
        a_valid = 1'b1; a_wr = 5'd3; a_wd = 32'hDEADBEEF;
        b_valid = 1'b0;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL a_only_ready: got a_ready=%b b_ready=%b expected 1/0", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0;
        checks++;
        if (RegWrite !== 1'b1 || WR !== 5'd3 || WD !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL a_only_write: got RegWrite=%b WR=%0d WD=%h expected 1/3/deadbeef", RegWrite, WR, WD);
        end
        #1;
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready: got a_ready=%b b_ready=%b expected 0/0", a_ready, b_ready);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b0 || WR !== 5'd3 || WD !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL idle_hold: got RegWrite=%b WR=%0d WD=%h expected 0/3/deadbeef", RegWrite, WR, WD);
        end
    endtask

    task automatic test_contention();
        logic [DEPTH-1:0] bw, aw;
        logic [WIDTH-1:0] bd, ad;
        bw = DEPTH'($urandom_range(1, 31));
        bd = $urandom();
        b_valid = 1'b1; b_wr = bw; b_wd = bd;
        for (int i = 0; i < 5; i++) begin
            aw = DEPTH'($urandom_range(1, 31));
            ad = $urandom();
            a_valid = 1'b1; a_wr = aw; a_wd = ad;
            #1;
            checks++;
            if (a_ready !== (i < 4) || b_ready !== (i == 4) || b_starved !== (i == 4)) begin
                failures++;
                $display("FAIL contention_grant[%0d]: got a_ready=%b b_ready=%b b_starved=%b expected %b/%b/%b",
                         i, a_ready, b_ready, b_starved, (i < 4), (i == 4), (i == 4));
            end
            tick();
            checks++;
            if (i < 4) begin
                if (RegWrite !== 1'b1 || WR !== aw || WD !== ad) begin
                    failures++;
                    $display("FAIL contention_a_write[%0d]: got RegWrite=%b WR=%0d WD=%h expected 1/%0d/%h", i, RegWrite, WR, WD, aw, ad);
                end
            end else begin
                if (RegWrite !== 1'b1 || WR !== bw || WD !== bd) begin
                    failures++;
                    $display("FAIL contention_b_write: got RegWrite=%b WR=%0d WD=%h expected 1/%0d/%h", RegWrite, WR, WD, bw, bd);
                end
            end
        end
        checks++;
        if (b_starved !== 1'b0) begin
            failures++;
            $display("FAIL contention_wait_clear: got b_starved=%b expected 0", b_starved);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
    endtask

    task automatic test_reg0();
        b_valid = 1'b1; b_wr = 5'd0; b_wd = 32'h1234;
        #1;
        checks++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            failures++;
            $display("FAIL reg0_ready: got b_ready=%b a_ready=%b expected 1/0", b_ready, a_ready);
        end
        tick();
        b_valid = 1'b0;
        checks++;
        if (RegWrite !== 1'b0 || WR !== 5'd0 || WD !== 32'h1234) begin
            failures++;
            $display("FAIL reg0_write: got RegWrite=%b WR=%0d WD=%h expected 0/0/1234", RegWrite, WR, WD);
        end
    endtask

    task automatic test_same_dest();
        a_valid = 1'b1; a_wr = 5'd7; a_wd = 32'd1;
        b_valid = 1'b1; b_wr = 5'd7; b_wd = 32'd2;
        #1;
        tick();
        a_valid = 1'b0;
        checks++;
        if (RegWrite !== 1'b1 || WR !== 5'd7 || WD !== 32'd1) begin
            failures++;
            $display("FAIL same_dest_first: got RegWrite=%b WR=%0d WD=%h expected 1/7/1", RegWrite, WR, WD);
        end
        #1;
        tick();
        b_valid = 1'b0;
        checks++;
        if (RegWrite !== 1'b1 || WR !== 5'd7 || WD !== 32'd2) begin
            failures++;
            $display("FAIL same_dest_second: got RegWrite=%b WR=%0d WD=%h expected 1/7/2", RegWrite, WR, WD);
        end
    endtask

    task automatic test_stall_hold();
        logic [DEPTH-1:0] bw;
        logic [WIDTH-1:0] bd;
        bw = DEPTH'($urandom_range(1, 31));
        bd = $urandom();
        b_valid = 1'b1; b_wr = bw; b_wd = bd;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1;
            a_wr = DEPTH'($urandom_range(1, 31));
            a_wd = $urandom();
            #1;
            checks++;
            if (b_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_denied[%0d]: got b_ready=%b expected 0", i, b_ready);
            end
            tick();
        end
        a_valid = 1'b0;
        #1;
        tick();
        b_valid = 1'b0;
        checks++;
        if (RegWrite !== 1'b1 || WR !== bw || WD !== bd) begin
            failures++;
            $display("FAIL stall_payload: got RegWrite=%b WR=%0d WD=%h expected 1/%0d/%h", RegWrite, WR, WD, bw, bd);
        end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] ad;
        ad = $urandom();
        a_valid = 1'b1; a_wr = 5'd9; a_wd = ad;
        b_valid = 1'b1; b_wr = 5'd11; b_wd = $urandom();
        #1;
        tick();
        checks++;
        if (RegWrite !== 1'b1 || WR !== 5'd9) begin
            failures++;
            $display("FAIL reset_mid_pre: got RegWrite=%b WR=%0d expected 1/9", RegWrite, WR);
        end
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (RegWrite !== 1'b0 || WR !== '0 || WD !== '0) begin
            failures++;
            $display("FAIL reset_mid_drop: got RegWrite=%b WR=%0d WD=%h expected 0/0/0", RegWrite, WR, WD);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_readys[%0d]: got a_ready=%b b_ready=%b expected 0/0", i, a_ready, b_ready);
            end
            tick();
        end
        @(negedge clk);
        rst = 1'b1;
        b_valid = 1'b0;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got a_ready=%b expected 1", a_ready);
        end
        tick();
        a_valid = 1'b0;
        checks++;
        if (RegWrite !== 1'b1 || WR !== 5'd9 || WD !== ad) begin
            failures++;
            $display("FAIL reset_release_write: got RegWrite=%b WR=%0d WD=%h expected 1/9/%h", RegWrite, WR, WD, ad);
        end
    endtask

    task automatic test_random();
        bit ea, eb;
        bit last_ga = 1'b0;
        bit last_gb = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!(a_valid && !last_ga)) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_wr = DEPTH'($urandom_range(0, 31));
                a_wd = $urandom();
            end
            if (!(b_valid && !last_gb)) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_wr = DEPTH'($urandom_range(0, 31));
                b_wd = $urandom();
            end
            #1;
            ea = exp_a_ready();
            eb = exp_b_ready();
            checks++;
            if (a_ready !== ea || b_ready !== eb || b_starved !== (m_wait == MAX_WAIT)) begin
                failures++;
                $display("FAIL rand_ready[%0d]: got a=%b b=%b starved=%b expected a=%b b=%b starved=%b",
                         n, a_ready, b_ready, b_starved, ea, eb, (m_wait == MAX_WAIT));
            end
            last_ga = ea;
            last_gb = eb;
            tick();
            checks++;
            if (RegWrite !== m_rw || WR !== m_wr || WD !== m_wd) begin
                failures++;
                $display("FAIL rand_write[%0d]: got RegWrite=%b WR=%0d WD=%h expected %b/%0d/%h",
                         n, RegWrite, WR, WD, m_rw, m_wr, m_wd);
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_contention();
        test_reg0();
        test_same_dest();
        test_stall_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
